// File: rtl/param_buffer.sv
// Streaming-loaded parameter store with handshaked burst reads and a registered output.
// Optional range checking and sticky err are enabled by defining PARAM_BUFFER_RANGE_CHECK_EN.
module param_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 20,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    // Load stream
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic signed [DATA_W-1:0] ld_data,
    output logic                     ld_ready,
    output logic                     loaded,
    // Burst request
    input  logic                     rd_start,
    input  logic        [ADDR_W-1:0] rd_base,
    input  logic        [ADDR_W:0]   rd_len,
    // Output stream
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     err
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CntTwo   = (ADDR_W + 1)'(2);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                     state_q, state_d;
    logic        [ADDR_W-1:0]   wp_q, wp_d;
    logic                       loaded_q, loaded_d;
    logic        [ADDR_W-1:0]   ptr_q, ptr_d;
    logic        [ADDR_W:0]     cnt_q, cnt_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic signed [DATA_W-1:0]   out_data_q, out_data_d;

    logic signed [DATA_W-1:0]   mem [DEPTH];

    logic                       idle;
    logic                       ld_restart;
    logic                       ld_fire;
    logic                       range_bad;
    logic                       rd_go;
    logic        [ADDR_W-1:0]   ptr_next;
    logic        [ADDR_W-1:0]   rd_addr;
    logic signed [DATA_W-1:0]   rd_word;

    assign idle       = (state_q == StIdle);
    // ld_start wins over a same-cycle load word, which is dropped.
    assign ld_restart = ld_start && idle;
    assign ld_fire    = ld_valid && !loaded_q && !ld_restart;

`ifdef PARAM_BUFFER_RANGE_CHECK_EN
    assign range_bad = (32'(rd_base) >= DEPTH) || (32'(rd_len) > DEPTH);
`else
    assign range_bad = 1'b0;
`endif

    assign rd_go = idle && rd_start && loaded_q && (rd_len != '0) && !range_bad;

    // Wrap at the last stored word; out-of-range pointers count on modulo 2^ADDR_W.
    assign ptr_next = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;

    // Fetch address for the word registered at the next edge.
    assign rd_addr = idle ? rd_base : ptr_next;
    assign rd_word = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

    always_comb begin
        wp_d     = wp_q;
        loaded_d = loaded_q;
        if (ld_restart) begin
            wp_d     = '0;
            loaded_d = 1'b0;
        end else if (ld_fire) begin
            if (wp_q == LastAddr) begin
                wp_d     = '0;
                loaded_d = 1'b1;
            end else begin
                wp_d = wp_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (rd_go) begin
                    state_d     = StRun;
                    ptr_d       = rd_base;
                    cnt_d       = rd_len;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_len == CntOne);
                    out_data_d  = rd_word;
                end
            end
            StRun: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_q == CntOne) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        ptr_d       = ptr_next;
                        cnt_d       = cnt_q - CntOne;
                        out_last_d  = (cnt_q == CntTwo);
                        out_data_d  = rd_word;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wp_q        <= '0;
            loaded_q    <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            loaded_q    <= loaded_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && ld_fire) begin
            mem[wp_q] <= ld_data;
        end
    end

`ifdef PARAM_BUFFER_RANGE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (ld_valid && loaded_q) begin
            err_d = 1'b1;
        end
        if (idle && rd_start && range_bad) begin
            err_d = 1'b1;
        end
        if (ld_restart) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ld_ready  = !loaded_q;
    assign loaded    = loaded_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_param_buffer.sv
// Scoreboard bench for param_buffer: stimulus pushes expected words, a negedge monitor checks them.
module tb_param_buffer;

    logic               clk = 1'b0;
    logic               rst;
    logic               ld_start;
    logic               ld_valid;
    logic        [15:0] ld_data;
    logic               ld_ready;
    logic               loaded;
    logic               rd_start;
    logic        [4:0]  rd_base;
    logic        [5:0]  rd_len;
    logic               out_valid;
    logic        [15:0] out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               err;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    param_buffer #(
        .DATA_W (16),
        .DEPTH  (20),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .loaded    (loaded),
        .rd_start  (rd_start),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] data, input logic last);
        exp_t e;
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && !rst) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h, expected no word at %0t",
                             out_data, $time);
                end else begin
                    check("out_data", {16'h0, out_data}, {16'h0, sb[0].data});
                    check("out_last", {31'h0, out_last}, {31'h0, sb[0].last});
                    if (out_ready) begin
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic load_all(input logic [15:0] first);
        for (int i = 0; i < 20; i++) begin
            ld_data  = first + 16'(i);
            ld_valid = 1'b1;
            check("ld_ready_during_load", {31'h0, ld_ready}, 32'h1);
            step();
        end
        ld_valid = 1'b0;
        check("loaded_after_load", {31'h0, loaded}, 32'h1);
        check("ld_ready_after_load", {31'h0, ld_ready}, 32'h0);
    endtask

    // stall: out_ready follows 1,0,0,1...; intr: a second rd_start arrives mid-burst.
    task automatic burst(input logic [4:0] base, input logic [5:0] len, input bit stall,
                         input bit intr, input int exp_cycles);
        int cycles;
        rd_base  = base;
        rd_len   = len;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check("first_word_latency", {31'h0, out_valid}, 32'h1);
        cycles = 0;
        while (busy && cycles < 200) begin
            out_ready = stall ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
            if (intr && cycles == 1) begin
                rd_start = 1'b1;
                rd_base  = 5'd10;
                rd_len   = 6'd3;
            end else begin
                rd_start = 1'b0;
            end
            step();
            cycles++;
        end
        rd_start  = 1'b0;
        out_ready = 1'b1;
        check("burst_cycles", 32'(cycles), 32'(exp_cycles));
        check("busy_after_burst", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        rd_start  = 1'b0;
        rd_base   = '0;
        rd_len    = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_loaded", {31'h0, loaded}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_out_last", {31'h0, out_last}, 32'h0);
        check("rst_out_data", {16'h0, out_data}, 32'h0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'h1);
        rst = 1'b0;
        step();

        // Read request before anything is loaded is ignored.
        rd_start = 1'b1;
        rd_base  = 5'd0;
        rd_len   = 6'd4;
        step();
        rd_start = 1'b0;
        check("unloaded_rd_valid", {31'h0, out_valid}, 32'h0);
        check("unloaded_rd_busy", {31'h0, busy}, 32'h0);

        load_all(16'h0001);

        // Zero-length request is ignored.
        rd_start = 1'b1;
        rd_base  = 5'd2;
        rd_len   = 6'd0;
        step();
        rd_start = 1'b0;
        check("zero_len_valid", {31'h0, out_valid}, 32'h0);
        check("zero_len_busy", {31'h0, busy}, 32'h0);

        push_exp(16'h0004, 1'b0);
        push_exp(16'h0005, 1'b0);
        push_exp(16'h0006, 1'b0);
        push_exp(16'h0007, 1'b1);
        burst(5'd3, 6'd4, 1'b0, 1'b0, 4);

        push_exp(16'h0013, 1'b0);
        push_exp(16'h0014, 1'b0);
        push_exp(16'h0001, 1'b0);
        push_exp(16'h0002, 1'b1);
        burst(5'd18, 6'd4, 1'b1, 1'b0, 8);

        push_exp(16'h0001, 1'b0);
        push_exp(16'h0002, 1'b0);
        push_exp(16'h0003, 1'b0);
        push_exp(16'h0004, 1'b0);
        push_exp(16'h0005, 1'b1);
        burst(5'd0, 6'd5, 1'b0, 1'b1, 5);

`ifdef PARAM_BUFFER_RANGE_CHECK_EN
        rd_start = 1'b1;
        rd_base  = 5'd25;
        rd_len   = 6'd2;
        step();
        rd_start = 1'b0;
        check("range_err_set", {31'h0, err}, 32'h1);
        check("range_no_burst", {31'h0, busy}, 32'h0);
        check("range_no_valid", {31'h0, out_valid}, 32'h0);
`else
        // Out-of-range pointer reads zero and wraps modulo 32.
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0001, 1'b0);
        push_exp(16'h0002, 1'b1);
        burst(5'd30, 6'd4, 1'b0, 1'b0, 4);
        check("no_range_err", {31'h0, err}, 32'h0);
`endif

        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("ld_start_err", {31'h0, err}, 32'h0);
        check("ld_start_loaded", {31'h0, loaded}, 32'h0);
        check("ld_start_ld_ready", {31'h0, ld_ready}, 32'h1);

        // Negative words pass through unmodified; reset lands after 2 of 5 words.
        load_all(16'hFF00);
        push_exp(16'hFF05, 1'b0);
        push_exp(16'hFF06, 1'b0);
        push_exp(16'hFF07, 1'b0);
        push_exp(16'hFF08, 1'b0);
        push_exp(16'hFF09, 1'b1);
        rd_base  = 5'd5;
        rd_len   = 6'd5;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_loaded", {31'h0, loaded}, 32'h0);
        check("midrst_words_taken", 32'(sb.size()), 32'd3);
        sb.delete();
        rst = 1'b0;
        step();

        load_all(16'hA001);
        push_exp(16'hA014, 1'b0);
        push_exp(16'hA001, 1'b1);
        burst(5'd19, 6'd2, 1'b0, 1'b0, 2);

        // Load word offered while full.
        ld_valid = 1'b1;
        ld_data  = 16'h1234;
        step();
        ld_valid = 1'b0;
`ifdef PARAM_BUFFER_RANGE_CHECK_EN
        check("overload_err", {31'h0, err}, 32'h1);
`else
        check("overload_err", {31'h0, err}, 32'h0);
`endif
        check("overload_still_loaded", {31'h0, loaded}, 32'h1);

        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_buffer.md
# param_buffer

Parametrised, streaming-loaded parameter store for the digit-recognition inference engine: holds one layer's biases or weights (DEPTH signed words of DATA_W bits). It is filled once through a valid/ready load stream with an auto-incrementing write pointer. It then serves burst reads (base, length) to the MAC datapath over a valid/ready output stream with a registered output. It generalises the fixed 20×16 bias memory in width and depth, and adds load tracking, handshaked bursts, wrap-around and error reporting.

## Interface
- DATA_W, 16, word width (signed)
- DEPTH, 20, number of words stored
- ADDR_W, 5, address/pointer width; must satisfy 2^ADDR_W ≥ DEPTH
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ld_start  in  1  pulse: restart load (write pointer←0, loaded←0, err←0)
- ld_valid  in  1  load word present
- ld_data  in  DATA_W  signed load word
- ld_ready  out  1  block accepts load word; combinational = !loaded
- loaded  out  1  all DEPTH words written
- rd_start  in  1  pulse: begin burst
- rd_base  in  ADDR_W  first word address
- rd_len  in  ADDR_W+1  burst length in words (1..DEPTH)
- out_valid  out  1  out_data holds a burst word
- out_data  out  DATA_W  signed registered read word
- out_last  out  1  out_data is the final word of the burst
- out_ready  in  1  consumer accepts word
- busy  out  1  burst in progress
- err  out  1  sticky rejected-request flag

## Operation
- Reset: wp=0, loaded=0, busy=0, out_valid=0, out_last=0, out_data=0, err=0, FSM=IDLE. Memory contents are not cleared.
- Load: when ld_valid&&ld_ready, mem[wp]←ld_data and wp←wp+1. The write that lands at wp==DEPTH-1 sets loaded=1 and clears wp to 0. While loaded=1, ld_ready=0 and writes are blocked.
- ld_start: honoured only in IDLE; ignored while busy. If ld_start and ld_valid occur in the same cycle, ld_start wins and the word is dropped.
- FSM IDLE→RUN: on rd_start when loaded=1 and rd_len≠0. The block captures ptr=rd_base and remaining count=rd_len. rd_start is ignored in IDLE if loaded=0 or rd_len=0, and ignored in RUN.
- RUN: out_data←mem[ptr] and out_valid=1. On out_valid&&out_ready:
  - if this was the last word: RUN→IDLE, out_valid←0, out_last←0, busy←0.
  - otherwise: ptr←next(ptr), count−1, and the next word is registered in the same edge.
- out_last=1 exactly when remaining count==1.
- Pointer wrap: next(DEPTH-1)=0; otherwise ptr+1.
- Holding: while out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Signed data passes through unmodified; there is no arithmetic on data.

## Timing
- Load write: one cycle per accepted word. loaded rises on the edge of the final accepted write; ld_ready falls in the same cycle.
- Read latency: rd_start sampled at edge N gives out_valid=1 with mem[rd_base] after edge N, i.e. visible in cycle N+1.
- Throughput: with out_ready held high, one word per cycle and no bubbles. A burst of L words completes at edge N+L; busy=0 from cycle N+L+1.
- The next rd_start is accepted in the first cycle busy=0.
- rst in mid-burst or mid-load aborts immediately and returns all outputs to their reset values on the next edge.

## Configuration
- PARAM_BUFFER_RANGE_CHECK_EN defined:
  - rd_start with rd_base≥DEPTH or rd_len>DEPTH is rejected: no burst is started and err←1.
  - ld_valid while ld_ready=0 sets err←1.
  - err clears only on rst or an accepted ld_start.
- PARAM_BUFFER_RANGE_CHECK_EN not defined:
  - err is tied to 0 and no request is rejected on range.
  - A pointer ≥DEPTH reads 0 and increments modulo 2^ADDR_W; wrap at DEPTH-1 still applies.

## Test plan
- Reset, then load 20 words 0x0001..0x0014 with ld_valid held high → ld_ready high for 20 cycles; loaded=1 after the 20th edge; ld_ready=0 after.
- Burst rd_base=3, rd_len=4, out_ready=1 → out_data 0x0004,0x0005,0x0006,0x0007 in consecutive cycles starting one cycle after rd_start; out_last on 0x0007; busy low the following cycle.
- Burst rd_base=18, rd_len=4 → 0x0013,0x0014,0x0001,0x0002 (wrap). Toggle out_ready 1,0,0,1… and check the data is held while stalled and no word is lost or duplicated.
- rd_start before loaded, and again with rd_len=0 → no out_valid, busy stays 0. rd_start during a burst is ignored.
- With RANGE_CHECK_EN: rd_base=25 → err=1 and no burst. Then ld_start → err=0, loaded=0, ld_ready=1.
- Assert rst mid-burst (after 2 of 5 words) → the next cycle shows out_valid=0, busy=0, loaded=0; a subsequent reload and burst return correct data.
